// File: rtl/ripple_count_sampler_if.sv
// ripple_count_sampler_if: count bus, error clear and event outputs of the ripple counter sampler
interface ripple_count_sampler_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  cnt_in;
    logic              clr_err;
    logic [WIDTH-1:0]  cnt_q;
    logic              in_sync;
    logic              dec_pulse;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err_pulse;
    logic              skip_err;
    modport master (
        output cnt_in, clr_err,
        input  cnt_q, in_sync, dec_pulse, wrap_pulse, wrap_cnt, err_pulse, skip_err
    );
    modport slave (
        input  cnt_in, clr_err,
        output cnt_q, in_sync, dec_pulse, wrap_pulse, wrap_cnt, err_pulse, skip_err
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronizes and glitch-filters a ripple down counter, emitting decrement/wrap/skip events
module ripple_count_sampler #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2,
    parameter int WRAP_W      = 8
) (
    input logic clk,
    input logic rst,
    ripple_count_sampler_if.slave bus
);
    localparam int RW = $clog2(STABLE_CYC + 1);
    localparam logic [RW-1:0] STAB    = RW'(STABLE_CYC);
    localparam logic [RW-1:0] STAB_M1 = RW'(STABLE_CYC - 1);
    typedef enum logic {INIT, TRACK} state_t;
    state_t state;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s, h, d;
    logic [RW-1:0] run, run_nxt;
    logic stable, accept, unit;
    assign s = sync_q[SYNC_STAGES-1];
    // run counts matches between successive synced samples; STABLE_CYC equal samples need STABLE_CYC-1 matches
    always_comb begin
        run_nxt = (s != h) ? '0 : (run == STAB) ? run : run + 1'b1;
        stable  = run_nxt >= STAB_M1;
        accept  = stable && (state == INIT || s != bus.cnt_q);
        d       = bus.cnt_q - s;
        unit    = d == WIDTH'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '{default: '1};
            h              <= '1;
            run            <= '0;
            state          <= INIT;
            bus.cnt_q      <= '1;
            bus.in_sync    <= 1'b0;
            bus.dec_pulse  <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.err_pulse  <= 1'b0;
            bus.wrap_cnt   <= '0;
            bus.skip_err   <= 1'b0;
        end else begin
            sync_q[0] <= bus.cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            h              <= s;
            run            <= run_nxt;
            bus.dec_pulse  <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.err_pulse  <= 1'b0;
            if (accept) begin
                bus.cnt_q   <= s;
                state       <= TRACK;
                bus.in_sync <= 1'b1;
            end
            if (accept && state == TRACK) begin
                bus.dec_pulse  <= unit;
                bus.wrap_pulse <= unit && bus.cnt_q == '0;
                bus.err_pulse  <= !unit;
                if (unit && bus.cnt_q == '0) bus.wrap_cnt <= bus.wrap_cnt + 1'b1;
            end
            // a skip on the same edge as clr_err keeps the flag set
            if (accept && state == TRACK && !unit) bus.skip_err <= 1'b1;
            else if (bus.clr_err) bus.skip_err <= 1'b0;
        end
    end
endmodule
